// File: rtl/collision_pkg.sv
// Shared types and helpers for the ball collision tracker.
package collision_pkg;

  typedef enum logic {
    ST_ARMED,
    ST_GRACE
  } player_state_t;

  localparam int unsigned MAX_BALLS = 16;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned SEL_W     = $clog2(MAX_BALLS);

  typedef struct packed {
    logic [SEL_W-1:0]     idx;
    logic [MAX_BALLS-1:0] onehot;
  } lowest_sel_t;

  // Lowest set bit of vec as index plus one-hot; all-zero onehot means none set.
  function automatic lowest_sel_t lowest_set(input logic [MAX_BALLS-1:0] vec);
    lowest_sel_t sel;
    logic        found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_BALLS; i++) begin
      if (vec[i] && !found) begin
        found         = 1'b1;
        sel.idx       = SEL_W'(i);
        sel.onehot[i] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/collision_channel.sv
// Per-ball frame accumulator: ORs collision terms over a frame and restarts
// from the current cycle's terms on each frame boundary.
import collision_pkg::*;

module collision_channel (
  input  logic clk,
  input  logic resetN,
  input  logic start_of_frame,
  input  logic player_term,
  input  logic rope_term,
  output logic player_acc,
  output logic rope_acc
);

  // Accumulate within a frame; reload on the boundary so coincident overlap is kept
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      player_acc <= 1'b0;
      rope_acc   <= 1'b0;
    end else if (start_of_frame) begin
      player_acc <= player_term;
      rope_acc   <= rope_term;
    end else begin
      player_acc <= player_acc | player_term;
      rope_acc   <= rope_acc | rope_term;
    end
  end

endmodule

// File: rtl/ball_collision_tracker.sv
// Per-frame collision tracker for player, rope and NUM_BALLS balls.
// Optional hit counters (popCount, playerHitCount) with COLLISION_HIT_COUNT_EN.
import collision_pkg::*;

module ball_collision_tracker #(
  parameter int NUM_BALLS    = 4,
  parameter int GRACE_FRAMES = 60,
  parameter int IDX_W        = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 playerRequest,
  input  logic                 ropeRequest,
  input  logic [NUM_BALLS-1:0] ballRequest,
  input  logic [NUM_BALLS-1:0] ballActive,
  output logic [NUM_BALLS-1:0] colPlayerBall,
  output logic [NUM_BALLS-1:0] colRopeBall,
  output logic                 playerHit,
  output logic                 ropeHit,
  output logic [IDX_W-1:0]     ropeBallIdx,
  output logic                 graceActive
`ifdef COLLISION_HIT_COUNT_EN
  ,
  output logic [7:0]           popCount,
  output logic [7:0]           playerHitCount
`endif
);

  logic [NUM_BALLS-1:0] ball_req;
  logic [NUM_BALLS-1:0] player_term;
  logic [NUM_BALLS-1:0] rope_term;
  logic [NUM_BALLS-1:0] player_acc;
  logic [NUM_BALLS-1:0] rope_acc;
  logic [MAX_BALLS-1:0] rope_acc_ext;
  lowest_sel_t          rope_sel;
  logic                 rope_any;
  logic                 unused_sel_bits;

  player_state_t        state;
  player_state_t        state_next;
  logic [CNT_W-1:0]     grace_cnt;
  logic [CNT_W-1:0]     grace_cnt_next;
  logic [NUM_BALLS-1:0] col_player_next;
  logic                 player_hit_next;

  assign ball_req    = ballRequest & ballActive;
  assign player_term = {NUM_BALLS{playerRequest}} & ball_req;
  assign rope_term   = {NUM_BALLS{ropeRequest}} & ball_req;

  for (genvar i = 0; i < NUM_BALLS; i++) begin : g_channel
    collision_channel u_channel (
      .clk            (clk),
      .resetN         (resetN),
      .start_of_frame (startOfFrame),
      .player_term    (player_term[i]),
      .rope_term      (rope_term[i]),
      .player_acc     (player_acc[i]),
      .rope_acc       (rope_acc[i])
    );
  end

  // Rope arbitration: pick the lowest-index ball popped during the frame
  always_comb begin
    rope_acc_ext                = '0;
    rope_acc_ext[NUM_BALLS-1:0] = rope_acc;
    rope_sel                    = lowest_set(rope_acc_ext);
    rope_any                    = |rope_sel.onehot;
  end

  // Selector bits above NUM_BALLS are always zero; fold them into a sink
  assign unused_sel_bits = ^{rope_sel.idx, rope_sel.onehot};

  // Rope event registers: one-cycle pulses after a boundary, index held between pops
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      colRopeBall <= '0;
      ropeHit     <= 1'b0;
      ropeBallIdx <= '0;
    end else if (startOfFrame) begin
      colRopeBall <= rope_sel.onehot[NUM_BALLS-1:0];
      ropeHit     <= rope_any;
      if (rope_any) begin
        ropeBallIdx <= IDX_W'(rope_sel.idx);
      end
    end else begin
      colRopeBall <= '0;
      ropeHit     <= 1'b0;
    end
  end

  // Player FSM next state: report when armed, count down grace frames otherwise
  always_comb begin
    state_next      = state;
    grace_cnt_next  = grace_cnt;
    col_player_next = '0;
    player_hit_next = 1'b0;
    if (startOfFrame) begin
      case (state)
        ST_ARMED: begin
          if (|player_acc) begin
            col_player_next = player_acc;
            player_hit_next = 1'b1;
            grace_cnt_next  = CNT_W'(GRACE_FRAMES);
            state_next      = ST_GRACE;
          end
        end
        ST_GRACE: begin
          grace_cnt_next = grace_cnt - CNT_W'(1);
          if (grace_cnt == CNT_W'(1)) begin
            state_next = ST_ARMED;
          end
        end
        default: state_next = ST_ARMED;
      endcase
    end
  end

  // Player FSM state, grace counter and registered player outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= ST_ARMED;
      grace_cnt     <= '0;
      colPlayerBall <= '0;
      playerHit     <= 1'b0;
    end else begin
      state         <= state_next;
      grace_cnt     <= grace_cnt_next;
      colPlayerBall <= col_player_next;
      playerHit     <= player_hit_next;
    end
  end

  assign graceActive = (state == ST_GRACE);

`ifdef COLLISION_HIT_COUNT_EN
  // Saturating event counters, updated together with their pulse registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      popCount       <= '0;
      playerHitCount <= '0;
    end else begin
      if (startOfFrame && rope_any && popCount != '1) begin
        popCount <= popCount + 8'd1;
      end
      if (player_hit_next && playerHitCount != '1) begin
        playerHitCount <= playerHitCount + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ball_collision_tracker.sv
// Self-checking bench for ball_collision_tracker (NUM_BALLS=4, GRACE_FRAMES=3).
module tb_ball_collision_tracker;

  localparam int N  = 4;
  localparam int G  = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          startOfFrame = 1'b0;
  logic          playerRequest = 1'b0;
  logic          ropeRequest = 1'b0;
  logic [N-1:0]  ballRequest = '0;
  logic [N-1:0]  ballActive = '0;
  logic [N-1:0]  colPlayerBall;
  logic [N-1:0]  colRopeBall;
  logic          playerHit;
  logic          ropeHit;
  logic [IW-1:0] ropeBallIdx;
  logic          graceActive;
`ifdef COLLISION_HIT_COUNT_EN
  logic [7:0]    popCount;
  logic [7:0]    playerHitCount;
`endif

  ball_collision_tracker #(
    .NUM_BALLS    (N),
    .GRACE_FRAMES (G)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .playerRequest (playerRequest),
    .ropeRequest   (ropeRequest),
    .ballRequest   (ballRequest),
    .ballActive    (ballActive),
    .colPlayerBall (colPlayerBall),
    .colRopeBall   (colRopeBall),
    .playerHit     (playerHit),
    .ropeHit       (ropeHit),
    .ropeBallIdx   (ropeBallIdx),
    .graceActive   (graceActive)
`ifdef COLLISION_HIT_COUNT_EN
    ,
    .popCount       (popCount),
    .playerHitCount (playerHitCount)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-frame sets of touched balls and frames of grace left
  logic [N-1:0] m_pacc, m_racc;
  int           m_grace;
  logic [N-1:0] e_colp, e_colr;
  logic         e_ph, e_rh;
  int           e_idx;
  int           e_pop, e_hits;

  function automatic void model_reset();
    m_pacc = '0; m_racc = '0; m_grace = 0;
    e_colp = '0; e_colr = '0; e_ph = 1'b0; e_rh = 1'b0;
    e_idx = 0; e_pop = 0; e_hits = 0;
  endfunction

  function automatic void model_step(input bit sof, input bit pr, input bit rr,
                                     input logic [N-1:0] br, input logic [N-1:0] ba);
    logic [N-1:0] rq, pt, rt, low;
    rq = br & ba;
    pt = pr ? rq : '0;
    rt = rr ? rq : '0;
    e_colp = '0; e_colr = '0; e_ph = 1'b0; e_rh = 1'b0;
    if (sof) begin
      if (m_racc != '0) begin
        low    = m_racc & (~m_racc + 1'b1);
        e_colr = low;
        e_rh   = 1'b1;
        e_idx  = $clog2(low);
        if (e_pop < 255) e_pop++;
      end
      if (m_grace > 0) begin
        m_grace--;
      end else if (m_pacc != '0) begin
        e_colp  = m_pacc;
        e_ph    = 1'b1;
        m_grace = G;
        if (e_hits < 255) e_hits++;
      end
      m_pacc = pt;
      m_racc = rt;
    end else begin
      m_pacc = m_pacc | pt;
      m_racc = m_racc | rt;
    end
  endfunction

  task automatic check_all();
    check("colPlayerBall", 32'(colPlayerBall), 32'(e_colp));
    check("colRopeBall", 32'(colRopeBall), 32'(e_colr));
    check("playerHit", 32'(playerHit), 32'(e_ph));
    check("ropeHit", 32'(ropeHit), 32'(e_rh));
    check("ropeBallIdx", 32'(ropeBallIdx), 32'(e_idx));
    check("graceActive", 32'(graceActive), 32'(m_grace > 0));
`ifdef COLLISION_HIT_COUNT_EN
    check("popCount", 32'(popCount), 32'(e_pop));
    check("playerHitCount", 32'(playerHitCount), 32'(e_hits));
`endif
  endtask

  // Apply one cycle of inputs (called at a falling edge), then check after the rising edge
  task automatic tick(input bit sof, input bit pr, input bit rr,
                      input logic [N-1:0] br, input logic [N-1:0] ba);
    startOfFrame  = sof;
    playerRequest = pr;
    ropeRequest   = rr;
    ballRequest   = br;
    ballActive    = ba;
    model_step(sof, pr, rr, br, ba);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    startOfFrame = 1'b0; playerRequest = 1'b0; ropeRequest = 1'b0;
    ballRequest = '0; ballActive = '0;
    model_reset();
    @(negedge clk);
    check_all();
    resetN = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: player on ball 2 for 5 cycles, reported after the next boundary
    tick(1, 0, 0, '0, 4'b0100);
    repeat (5) tick(0, 1, 0, 4'b0100, 4'b0100);
    tick(1, 0, 0, '0, 4'b0100);
    check("t1_colp", 32'(colPlayerBall), 32'h4);
    check("t1_hit", 32'(playerHit), 32'h1);
    check("t1_grace", 32'(graceActive), 32'h1);
    tick(0, 0, 0, '0, 4'b0100);
    check("t1_pulse_len", 32'(playerHit), 32'h0);

    // 2: rope on balls 1 and 3, only the lower index is reported
    do_reset();
    tick(1, 0, 0, '0, '1);
    tick(0, 0, 1, 4'b1010, '1);
    tick(0, 0, 1, 4'b1000, '1);
    tick(1, 0, 0, '0, '1);
    check("t2_colr", 32'(colRopeBall), 32'h2);
    check("t2_rhit", 32'(ropeHit), 32'h1);
    check("t2_idx", 32'(ropeBallIdx), 32'h1);
    tick(0, 0, 0, '0, '1);
    check("t2_idx_held", 32'(ropeBallIdx), 32'h1);

    // 3: player hits ball 0 every frame; grace window of 3 frames
    do_reset();
    for (int f = 0; f <= 6; f++) begin
      tick(1, 0, 0, '0, '1);
      check($sformatf("t3_hit_b%0d", f), 32'(playerHit), 32'((f == 1) || (f == 5)));
      check($sformatf("t3_grace_b%0d", f), 32'(graceActive),
            32'(((f >= 1) && (f <= 3)) || (f >= 5)));
      if (f < 6) repeat (2) tick(0, 1, 0, 4'b0001, '1);
    end

    // 4: inactive ball 0 touched by the rope is ignored
    do_reset();
    tick(1, 0, 0, '0, 4'b1110);
    tick(0, 0, 1, 4'b0001, 4'b1110);
    tick(1, 0, 0, '0, 4'b1110);
    check("t4_rhit", 32'(ropeHit), 32'h0);
    check("t4_colr", 32'(colRopeBall), 32'h0);

    // 5: overlap on the boundary cycle belongs to the new frame
    do_reset();
    tick(1, 0, 0, '0, '1);
    tick(0, 0, 0, '0, '1);
    tick(1, 1, 0, 4'b0001, '1);
    check("t5_not_now", 32'(playerHit), 32'h0);
    tick(0, 0, 0, '0, '1);
    tick(1, 0, 0, '0, '1);
    check("t5_next", 32'(playerHit), 32'h1);
    check("t5_colp", 32'(colPlayerBall), 32'h1);

    // 6: reset mid-frame discards the pending player hit
    do_reset();
    tick(1, 0, 0, '0, '1);
    repeat (2) tick(0, 1, 0, 4'b0010, '1);
    #2 resetN = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    resetN = 1'b1;
    tick(0, 0, 0, '0, '1);
    tick(1, 0, 0, '0, '1);
    check("t6_hit", 32'(playerHit), 32'h0);
    check("t6_colp", 32'(colPlayerBall), 32'h0);

`ifdef COLLISION_HIT_COUNT_EN
    // 300 rope pops saturate popCount
    do_reset();
    for (int k = 0; k < 300; k++) begin
      tick(1, 0, 0, '0, '1);
      tick(0, 0, 1, 4'b0001, '1);
    end
    tick(1, 0, 0, '0, '1);
    check("pop_sat", 32'(popCount), 32'd255);
`endif

    // Randomised traffic against the model, including mid-frame deactivation
    do_reset();
    begin
      logic [N-1:0] act;
      act = '1;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 19) == 0) act = N'($urandom);
        tick($urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, N'($urandom) & N'($urandom), act);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
